// File: rtl/pr_stage_skid.sv
// pr_stage_skid: pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
//   It also provides flush, bubble control masking and saturating bubble/stall counters.
//   clk, rst_n            : clock, synchronous active-low reset
//   flush                 : drop all held entries and discard this cycle's input
//   in_valid/in_ready     : upstream handshake; in_ready depends only on state
//   ctrl_in/data_in/instru_in : incoming payload
//   out_valid/out_ready   : downstream handshake
//   ctrl/data/instru      : outgoing payload; ctrl is zero when out_valid is 0
//   occupancy             : number of held entries (0..2)
//   bubble_cnt/stall_cnt  : saturating performance counters
module pr_stage_skid #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 37,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [31:0]       instru_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data,
    output logic [31:0]       instru,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t            r_state, w_next;
    logic [CTRL_W-1:0] r_m_ctrl, r_s_ctrl;
    logic [DATA_W-1:0] r_m_data, r_s_data;
    logic [31:0]       r_m_instru, r_s_instru;
    logic [CNT_W-1:0]  r_bubble_cnt, r_stall_cnt;
    logic              w_accept, w_pop, w_load_m_in, w_load_m_s, w_load_s;

    // in_ready comes straight from the state register, so upstream never sees a combinational path
    assign in_ready   = r_state != FULL;
    assign out_valid  = (r_state != EMPTY) & ~flush;
    assign w_accept   = in_valid & in_ready & ~flush;
    assign w_pop      = out_valid & out_ready;
    assign ctrl       = out_valid ? r_m_ctrl : '0;
    assign data       = r_m_data;
    assign instru     = r_m_instru;
    assign occupancy  = r_state;
    assign bubble_cnt = r_bubble_cnt;
    assign stall_cnt  = r_stall_cnt;

    // accept and pop are already masked by flush, so no payload loads during a flush
    always_comb begin
        w_next      = r_state;
        w_load_m_in = 1'b0;
        w_load_m_s  = 1'b0;
        w_load_s    = 1'b0;
        if (flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_accept) begin
                    w_next      = ONE;
                    w_load_m_in = 1'b1;
                end
                ONE: if (w_accept && !w_pop) begin
                    w_next   = FULL;
                    w_load_s = 1'b1;
                end else if (w_accept) begin
                    w_load_m_in = 1'b1;
                end else if (w_pop) begin
                    w_next = EMPTY;
                end
                FULL: if (w_pop) begin
                    w_next     = ONE;
                    w_load_m_s = 1'b1;
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_m_ctrl     <= '0;
            r_m_data     <= '0;
            r_m_instru   <= '0;
            r_s_ctrl     <= '0;
            r_s_data     <= '0;
            r_s_instru   <= '0;
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_m_in) begin
                r_m_ctrl   <= ctrl_in;
                r_m_data   <= data_in;
                r_m_instru <= instru_in;
            end else if (w_load_m_s) begin
                r_m_ctrl   <= r_s_ctrl;
                r_m_data   <= r_s_data;
                r_m_instru <= r_s_instru;
            end
            if (w_load_s) begin
                r_s_ctrl   <= ctrl_in;
                r_s_data   <= data_in;
                r_s_instru <= instru_in;
            end
            if (!out_valid && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (out_valid && !out_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
endmodule
